// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers.
//   - stg_state_e : 2-bit stage state encoding (EMPTY / FULL / SKID)
//   - per-boundary payload widths and NOP payloads, assembled from the
//     classic NOP field values so every boundary squashes to a harmless op
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'b00,
    STG_FULL  = 2'b01,
    STG_SKID  = 2'b10
  } stg_state_e;

  // NOP field values shared by the decode/execute/writeback boundaries
  localparam logic [7:0] EXE_NOP_OP    = 8'h00;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [4:0] NOP_REG_ADDR  = 5'b00000;
  localparam logic       WRITE_DISABLE = 1'b0;

  // IF/ID: pc + instruction word
  localparam int IF_ID_W = 64;
  localparam logic [IF_ID_W-1:0] IF_ID_NOP = '0;

  // ID/EX: op, result type, two operands, destination, write enable
  localparam int ID_EX_W = 8 + 3 + 32 + 32 + 5 + 1;
  localparam logic [ID_EX_W-1:0] ID_EX_NOP =
    {EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, NOP_REG_ADDR, WRITE_DISABLE};

  // EX/MEM: result, destination, write enable
  localparam int EX_MEM_W = 32 + 5 + 1;
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {32'h0, NOP_REG_ADDR, WRITE_DISABLE};

  // MEM/WB: write-back data, destination, write enable
  localparam int MEM_WB_W = 32 + 5 + 1;
  localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = {32'h0, NOP_REG_ADDR, WRITE_DISABLE};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
//   clk : clock
//   rst : asynchronous reset, active-low, clears the count
//   inc : add one this cycle (ignored once the count is all-ones)
//   cnt : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshake pipeline stage register with a one-entry skid buffer.
//   clk, rst        : clock; asynchronous active-low reset
//   flush           : synchronous squash back to EMPTY with NOP payload
//   in_valid/ready  : upstream handshake, in_data payload
//   out_valid/ready : downstream handshake, out_data payload
//   stall_cnt       : saturating count of out_valid & !out_ready cycles
//   bubble_cnt      : saturating count of !out_valid & out_ready cycles
//   dbg_state       : current stage state (stg_state_e encoding)
//
// Handshake: a payload moves across a boundary on a rising edge where both
// valid and ready are high. A producer holding valid keeps its payload stable
// until it is taken; ready never depends combinationally on valid. Here both
// in_ready and out_valid are decoded from the state flop only.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [1:0]        dbg_state
);

  stg_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic accept;
  logic send;

  assign out_valid = (state_q != STG_EMPTY);
  assign in_ready  = (state_q != STG_SKID);
  assign out_data  = main_q;
  assign dbg_state = state_q;

  assign accept = in_valid & in_ready;
  assign send   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = STG_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        STG_EMPTY: begin
          if (accept) begin
            state_d = STG_FULL;
            main_d  = in_data;
          end
        end
        STG_FULL: begin
          if (accept && send) begin
            main_d = in_data;
          end else if (accept) begin
            // downstream stalled: park the new payload behind main
            state_d = STG_SKID;
            skid_d  = in_data;
          end else if (send) begin
            state_d = STG_EMPTY;
            main_d  = NOP_VAL;
          end
        end
        STG_SKID: begin
          if (send) begin
            state_d = STG_FULL;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          // unreachable encoding: recover to a clean empty stage
          state_d = STG_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STG_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // counters see the pre-edge handshake, flush cycles included
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~out_valid & out_ready),
    .cnt (bubble_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshake-based pipeline stage register. Generalised successor to the fixed stall-vector stage registers (if/id, id/ex, ex/mem, mem/wb).
- Carries one opaque payload of DATA_W bits per transfer over a valid/ready handshake.
- Contains a one-entry skid buffer, so in_ready is registered and full throughput is kept.
- Synchronous flush loads the NOP payload, for branch/exception squash.
- Saturating performance counters record stall cycles and bubble cycles.

Parameters:
- DATA_W, 32: payload width in bits (≥1).
- NOP_VAL, {DATA_W{1'b0}}: payload driven when empty, after flush and after reset (e.g. concatenated EXE_NOP_OP / EXE_RES_NOP / NOPRegAddr / WriteDisable fields).
- CNT_W, 16: performance counter width (≥2).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset asserted).
- flush  in  1  synchronous squash, highest priority after reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered, function of state only.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered payload; equals NOP_VAL whenever out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1, saturating.

Behaviour:
- Storage is a main register (drives out_data) plus a skid register. State is EMPTY, FULL or SKID; encoding is a 2-bit localparam.
- Reset (rst=0, asynchronous):
  - state=EMPTY; main and skid = NOP_VAL.
  - out_valid=0, in_ready=1, both counters=0.
  - Takes effect mid-transfer; any in-flight payload is lost.
- Outputs: out_valid = (state≠EMPTY); in_ready = (state≠SKID). There is no combinational path from any input to any output.
- Accept and send: accept = in_valid & in_ready; send = out_valid & out_ready.
- Latency: a payload accepted in cycle N appears on out_data in cycle N+1 when the stage was EMPTY, or when it was FULL with send. Throughput is 1 transfer per cycle.
- EMPTY:
  - accept → FULL, main ← in_data.
  - otherwise stay EMPTY.
- FULL:
  - accept & send → FULL, main ← in_data.
  - accept & !send → SKID, skid ← in_data.
  - !accept & send → EMPTY, main ← NOP_VAL.
  - neither → hold.
- SKID:
  - send → FULL, main ← skid, skid ← NOP_VAL.
  - otherwise hold.
  - in_ready=0, so in_data is ignored.
- Ordering: payloads leave strictly in acceptance order. Nothing is duplicated or dropped except on flush or reset.
- Flush (flush=1 at posedge):
  - state ← EMPTY; main, skid ← NOP_VAL.
  - Overrides a simultaneous accept or send. A simultaneous in_valid payload is discarded even though in_ready=1 that cycle.
  - Next cycle: out_valid=0, in_ready=1.
  - Flush while EMPTY is a no-op.
- Counters:
  - Evaluated every non-reset cycle from the pre-edge out_valid/out_ready, including flush cycles.
  - Each increments by 1 and holds at all-ones (2^CNT_W−1); there is no wrap.
  - Flush does not clear them; only reset does.
- in_data is sampled only on accept; X on in_data while in_valid=0 must not propagate.

Decomposition:
- Shared package / define.v holds:
  - The stage state encodings (STG_EMPTY, STG_FULL, STG_SKID).
  - Per-boundary NOP payload constants built from the existing NOP defines.
  - Per-boundary DATA_W localparams for each pipeline boundary.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst, inc; output cnt). It is instantiated twice.

Test Plan:
- Reset, then single transfer. Assert rst=0 mid-run; expect out_valid=0, in_ready=1, out_data=NOP_VAL, counters=0. Release rst; drive in_valid=1, in_data=0xA5A5_0001, out_ready=1 for one cycle; expect out_valid=1, out_data=0xA5A5_0001 the next cycle, then EMPTY.
- Streaming. Send 100 back-to-back payloads 0..99 with out_ready=1; expect output 0..99 in order, one per cycle from cycle 1, and in_ready never low.
- Backpressure and skid. Hold out_ready=0 and offer payloads 0x10, 0x11, 0x12; expect 0x10 on out_data, 0x11 in skid, in_ready=0 after the second accept, 0x12 held upstream. Release out_ready; expect output 0x10, 0x11, 0x12 with no loss; stall_cnt equals the cycles out_ready was held low while valid.
- Flush in SKID with a simultaneous offer. Flush=1 while SKID and in_valid=1 (0x77); expect out_valid=0, out_data=NOP_VAL, in_ready=1 next cycle, and 0x77, 0x10, 0x11 never appear.
- Counter saturation. Use CNT_W=2, keep EMPTY with out_ready=1 for 6 cycles; expect bubble_cnt 1,2,3,3,3,3.
- Async reset while FULL. Drive rst=0 between clock edges; expect outputs at reset values immediately, without waiting for a clock edge.
